// File: rtl/histogram_mc_if.sv
// histogram_mc_if
//   Groups the pixel input stream and the dump output stream of histogram_mc.
//   in_valid / in_data / in_ready          : packed multi-channel pixel samples
//   out_valid / out_ready                  : dump word handshake
//   out_ch / out_bin / out_count / out_last: dump word payload
//   Modport slave is the histogram's view; master is the pixel source / stats sink view.
interface histogram_mc_if #(
  parameter int DATA_WIDTH = 8,
  parameter int BIN_BITS   = 8,
  parameter int NUM_CH     = 3,
  parameter int HIST_WIDTH = 20
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                         in_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] in_data;
  logic                         in_ready;
  logic                         out_valid;
  logic                         out_ready;
  logic [CH_W-1:0]              out_ch;
  logic [BIN_BITS-1:0]          out_bin;
  logic [HIST_WIDTH-1:0]        out_count;
  logic                         out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_ch, out_bin, out_count, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_ch, out_bin, out_count, out_last
  );
endinterface

// File: rtl/histogram_mc.sv
// histogram_mc
//   Multi-channel frame histogram. Each of NUM_CH channels owns 2^BIN_BITS saturating
//   counters. A frame is CLEAR (zero every bin), COUNT (one increment per channel per
//   accepted beat), then DUMP (channel-major readout over a valid/ready stream).
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   frame_start  : pulse, starts a new frame (IDLE or COUNT)
//   frame_end    : pulse, ends counting and starts the dump (COUNT only)
//   bus          : histogram_mc_if slave modport (pixel input + dump output streams)
//   sat_flag     : sticky, a counter was saturated during this frame
//   drop_flag    : sticky, in_valid was presented while not ready outside IDLE
//   state_out    : IDLE=0, CLEAR=1, COUNT=2, DUMP=3
module histogram_mc #(
  parameter int DATA_WIDTH = 8,
  parameter int BIN_BITS   = 8,
  parameter int NUM_CH     = 3,
  parameter int HIST_WIDTH = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_start,
  input  logic                frame_end,
  histogram_mc_if.slave       bus,
  output logic                sat_flag,
  output logic                drop_flag,
  output logic [1:0]          state_out
);
  localparam int NBINS = 1 << BIN_BITS;
  localparam int SHIFT = DATA_WIDTH - BIN_BITS;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, COUNT = 2'd2, DUMP = 2'd3} state_e;

  state_e                state_q, state_d;
  logic [BIN_BITS-1:0]   clr_addr_q, clr_addr_d;
  logic [CH_W-1:0]       dump_ch_q, dump_ch_d;
  logic [BIN_BITS-1:0]   dump_bin_q, dump_bin_d;
  logic                  dump_done_q, dump_done_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [CH_W-1:0]       out_ch_q, out_ch_d;
  logic [BIN_BITS-1:0]   out_bin_q, out_bin_d;
  logic [HIST_WIDTH-1:0] out_count_q, out_count_d;
  logic                  out_last_q, out_last_d;
  logic                  sat_q, sat_d;
  logic                  drop_q, drop_d;

  // Counter storage is deliberately not reset; the CLEAR pass defines it.
  logic [HIST_WIDTH-1:0] hist_mem [NUM_CH][NBINS];

  logic [BIN_BITS-1:0]   bin_s  [NUM_CH];
  logic [HIST_WIDTH-1:0] cur_s  [NUM_CH];
  logic [HIST_WIDTH-1:0] inc_s  [NUM_CH];
  logic [NUM_CH-1:0]     full_s;
  logic                  accept_s;
  logic                  last_word_s;
  logic [HIST_WIDTH-1:0] dump_rd_s;

  // in_ready_q is high exactly while in COUNT, so it alone qualifies a beat.
  assign accept_s = bus.in_valid & in_ready_q;

  // Per-channel bin lookup and saturating increment of the addressed counter.
  // Read and write of a bin happen in the same cycle, so a following beat to the
  // same bin always reads the already-committed value: no stall, no hazard.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      bin_s[ch]  = bus.in_data[ch*DATA_WIDTH + SHIFT +: BIN_BITS];
      cur_s[ch]  = hist_mem[ch][bin_s[ch]];
      full_s[ch] = &cur_s[ch];
      if (full_s[ch]) begin
        inc_s[ch] = cur_s[ch];
      end else begin
        inc_s[ch] = cur_s[ch] + HIST_WIDTH'(1);
      end
    end
  end

  // Counter memory write port: zeroing during CLEAR, increments during COUNT.
  always_ff @(posedge clk) begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (state_q == CLEAR) begin
        hist_mem[ch][clr_addr_q] <= '0;
      end else if (accept_s) begin
        hist_mem[ch][bin_s[ch]] <= inc_s[ch];
      end
    end
  end

  // Frame sequencing, dump word loading and sticky flag next-state logic.
  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    dump_ch_d   = dump_ch_q;
    dump_bin_d  = dump_bin_q;
    dump_done_d = dump_done_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    out_bin_d   = out_bin_q;
    out_count_d = out_count_q;
    out_last_d  = out_last_q;
    sat_d       = sat_q;
    drop_d      = drop_q;
    dump_rd_s   = hist_mem[dump_ch_q][dump_bin_q];
    last_word_s = (dump_ch_q == CH_W'(NUM_CH - 1)) && (&dump_bin_q);

    if (bus.in_valid && !in_ready_q && (state_q != IDLE)) begin
      drop_d = 1'b1;
    end else begin
      drop_d = drop_q;
    end
    if (accept_s && (|full_s)) begin
      sat_d = 1'b1;
    end else begin
      sat_d = sat_q;
    end

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
          sat_d      = 1'b0;
          drop_d     = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        clr_addr_d = clr_addr_q + BIN_BITS'(1);
        if (&clr_addr_q) begin
          state_d = COUNT;
        end else begin
          state_d = CLEAR;
        end
      end
      COUNT: begin
        if (frame_start) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
          sat_d      = 1'b0;
          drop_d     = 1'b0;
        end else if (frame_end) begin
          // The frame_end beat commits on this edge, so DUMP sees final counts.
          state_d     = DUMP;
          dump_ch_d   = '0;
          dump_bin_d  = '0;
          dump_done_d = 1'b0;
        end else begin
          state_d = COUNT;
        end
      end
      DUMP: begin
        if (out_valid_q && bus.out_ready && out_last_q) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = IDLE;
        end else if ((!out_valid_q || bus.out_ready) && !dump_done_q) begin
          // Output slot is free (empty or being taken): load the next word.
          out_valid_d = 1'b1;
          out_ch_d    = dump_ch_q;
          out_bin_d   = dump_bin_q;
          out_count_d = dump_rd_s;
          out_last_d  = last_word_s;
          dump_done_d = last_word_s;
          if (&dump_bin_q) begin
            dump_bin_d = '0;
            dump_ch_d  = dump_ch_q + CH_W'(1);
          end else begin
            dump_bin_d = dump_bin_q + BIN_BITS'(1);
          end
        end else begin
          state_d = DUMP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = (state_d == COUNT);
  end

  // State, control and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      clr_addr_q  <= '0;
      dump_ch_q   <= '0;
      dump_bin_q  <= '0;
      dump_done_q <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_bin_q   <= '0;
      out_count_q <= '0;
      out_last_q  <= 1'b0;
      sat_q       <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      dump_ch_q   <= dump_ch_d;
      dump_bin_q  <= dump_bin_d;
      dump_done_q <= dump_done_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_bin_q   <= out_bin_d;
      out_count_q <= out_count_d;
      out_last_q  <= out_last_d;
      sat_q       <= sat_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_bin   = out_bin_q;
  assign bus.out_count = out_count_q;
  assign bus.out_last  = out_last_q;
  assign sat_flag      = sat_q;
  assign drop_flag     = drop_q;
  assign state_out     = state_q;
endmodule

// File: tb/tb_histogram_mc.sv
// tb_histogram_mc
//   Directed frames against histogram_mc configured with 16 bins per channel and
//   10-bit counters (saturation at 1023 is reachable in a short run). Stimulus
//   pushes the expected dump words into a queue when frame_end is issued; a
//   separate monitor pops and compares on every dump transfer and checks that a
//   stalled word is held stable.
module tb_histogram_mc;
  localparam int DW = 8;
  localparam int BB = 4;
  localparam int NC = 3;
  localparam int HW = 10;
  localparam int NBINS = 16;
  localparam int CMAX = 1023;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       frame_end = 1'b0;
  logic       sat_flag;
  logic       drop_flag;
  logic [1:0] state_out;

  histogram_mc_if #(.DATA_WIDTH(DW), .BIN_BITS(BB), .NUM_CH(NC), .HIST_WIDTH(HW)) bus ();

  histogram_mc #(.DATA_WIDTH(DW), .BIN_BITS(BB), .NUM_CH(NC), .HIST_WIDTH(HW)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .frame_end(frame_end),
    .bus(bus), .sat_flag(sat_flag), .drop_flag(drop_flag), .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int bin;
    int cnt;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   words_seen = 0;
  int   model [NC][NBINS];
  bit   exp_sat = 1'b0;
  bit   exp_drop = 1'b0;
  bit   rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Downstream ready: always 1, or a random toggle per cycle.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pop and compare on each transfer, check holds while stalled.
  initial begin
    exp_t       e;
    bit         stall_prev = 1'b0;
    logic [1:0] p_ch;
    logic [3:0] p_bin;
    logic [9:0] p_cnt;
    logic       p_last;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          checks++;
          if (bus.out_valid !== 1'b1 || bus.out_ch !== p_ch || bus.out_bin !== p_bin ||
              bus.out_count !== p_cnt || bus.out_last !== p_last) begin
            failures++;
            $display("FAIL hold_stable actual v=%0b ch=%0d bin=%0d cnt=%0d expected ch=%0d bin=%0d cnt=%0d",
                     bus.out_valid, bus.out_ch, bus.out_bin, bus.out_count, p_ch, p_bin, p_cnt);
          end
        end
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
          words_seen++;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_word actual ch=%0d bin=%0d cnt=%0d expected none",
                     bus.out_ch, bus.out_bin, bus.out_count);
          end else begin
            e = exp_q.pop_front();
            if (bus.out_ch !== 2'(e.ch) || bus.out_bin !== 4'(e.bin) ||
                bus.out_count !== 10'(e.cnt) || bus.out_last !== e.last) begin
              failures++;
              $display("FAIL dump_word actual ch=%0d bin=%0d cnt=%0d last=%0b expected ch=%0d bin=%0d cnt=%0d last=%0b",
                       bus.out_ch, bus.out_bin, bus.out_count, bus.out_last, e.ch, e.bin, e.cnt, e.last);
            end
          end
        end
        stall_prev = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
        p_ch   = bus.out_ch;
        p_bin  = bus.out_bin;
        p_cnt  = bus.out_count;
        p_last = bus.out_last;
      end
    end
  end

  // Pulse frame_start, run out CLEAR (optionally offering one sample during it).
  task automatic start_frame(input bit probe);
    int n;
    for (int c = 0; c < NC; c++) begin
      for (int b = 0; b < NBINS; b++) model[c][b] = 0;
    end
    exp_sat    = 1'b0;
    exp_drop   = probe;
    words_seen = 0;
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      bus.in_valid = probe && (n == 2);
      bus.in_data  = 24'hAAAAAA;
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    check("clear_cycles", n, 16);
    check("sat_after_start", sat_flag, 1'b0);
    check("drop_after_clear", drop_flag, probe);
  endtask

  // One accepted beat; on the frame_end beat the full expected dump is queued.
  task automatic beat(input logic [23:0] d, input bit fe);
    int b;
    for (int c = 0; c < NC; c++) begin
      b = int'(d[c*DW +: DW]) >> (DW - BB);
      if (model[c][b] == CMAX) exp_sat = 1'b1;
      else model[c][b] = model[c][b] + 1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    frame_end    = fe;
    @(negedge clk);
    check("in_ready_count", bus.in_ready, 1'b1);
    if (fe) begin
      for (int c = 0; c < NC; c++) begin
        for (int k = 0; k < NBINS; k++) begin
          exp_q.push_back('{ch: c, bin: k, cnt: model[c][k], last: (c == NC - 1) && (k == NBINS - 1)});
        end
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    frame_end    = 1'b0;
  endtask

  // Follow the dump to completion and check end-of-frame status.
  task automatic finish_frame();
    int n;
    @(negedge clk);
    check("state_dump", state_out, 2'd3);
    check("in_ready_drop", bus.in_ready, 1'b0);
    @(negedge clk);
    check("first_valid", bus.out_valid, 1'b1);
    n = 0;
    while ((bus.out_valid !== 1'b0 || state_out !== 2'd0 || exp_q.size() != 0) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("dump_in_time", (n < 3000) ? 1 : 0, 1);
    check("queue_drained", exp_q.size(), 0);
    check("words_seen", words_seen, NC * NBINS);
    check("sat_flag", sat_flag, exp_sat);
    check("drop_flag", drop_flag, exp_drop);
  endtask

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", state_out, 2'd0);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_last", bus.out_last, 1'b0);
    check("rst_flags", {sat_flag, drop_flag}, 2'b00);
    check("rst_out_word", {bus.out_ch, bus.out_bin, bus.out_count}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // frame_end in IDLE has no effect.
    frame_end = 1'b1;
    @(posedge clk);
    #1;
    frame_end = 1'b0;
    @(negedge clk);
    check("idle_frame_end", state_out, 2'd0);

    // Frame 1: ch0=0x00 (bin0), ch1=0x80 (bin8), ch2=0xFF (bin15), 16 beats.
    rand_ready = 1'b0;
    start_frame(1'b0);
    for (int i = 0; i < 16; i++) beat(24'hFF8000, i == 15);
    finish_frame();

    // Frame 2: 1000 back-to-back beats into one bin per channel, random ready.
    rand_ready = 1'b1;
    start_frame(1'b0);
    for (int i = 0; i < 1000; i++) beat(24'h332211, i == 999);
    finish_frame();

    // Frame 3: bin boundaries 0x00,0x0F,0x10,0xFF -> bin0=2, bin1=1, bin15=1.
    start_frame(1'b0);
    beat(24'h000000, 1'b0);
    beat(24'h0F0F0F, 1'b0);
    beat(24'h101010, 1'b0);
    beat(24'hFFFFFF, 1'b1);
    finish_frame();

    // Frame 4: 1030 beats in bin7 -> saturates at 1023, sat_flag set.
    rand_ready = 1'b0;
    start_frame(1'b0);
    for (int i = 0; i < 1030; i++) beat(24'h7F7F7F, i == 1029);
    finish_frame();

    // Frame 5: sat_flag cleared by start; reset mid-COUNT discards the frame.
    start_frame(1'b0);
    for (int i = 0; i < 3; i++) beat(24'h555555, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_mid_state", state_out, 2'd0);
    check("reset_mid_in_ready", bus.in_ready, 1'b0);

    // Frame 6: sample offered during CLEAR is dropped, then 5 beats only.
    rand_ready = 1'b1;
    start_frame(1'b1);
    beat(24'hC04020, 1'b0);
    beat(24'hC14121, 1'b0);
    beat(24'h0000F0, 1'b0);
    beat(24'hFFFFFF, 1'b0);
    beat(24'h123456, 1'b1);
    finish_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
